// File: rtl/serial_comp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state type
// and the default operand width.
package serial_comp_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bit_cmp.sv
// Purely combinational single-bit comparator: classifies one a/b bit pair
// as greater, equal or less. Exactly one output is high for any input.
module bit_cmp (
    input  logic a_i,
    input  logic b_i,
    output logic gt_o,
    output logic eq_o,
    output logic lt_o
);

    // One-hot decision for the current bit pair
    always_comb begin
        gt_o = a_i & ~b_i;
        lt_o = ~a_i & b_i;
        eq_o = ~(a_i ^ b_i);
    end

endmodule

// File: rtl/serial_mag_comp.sv
// Serial magnitude comparator. Operands arrive MSB first as bit pairs under
// a valid/ready handshake; once all WIDTH pairs are consumed the result is
// registered on o1 (A > B), o2 (A == B), o3 (A < B) and done pulses once.
//
// Optional feature macro: SERIAL_COMP_EARLY_TERM_EN -- when defined, the
// transfer that first distinguishes A from B ends the operation at once and
// the remaining bit pairs are not consumed.
module serial_mag_comp
    import serial_comp_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic bit_ready,
    output logic busy,
    output logic done,
    output logic o1,
    output logic o2,
    output logic o3
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

    state_e          state_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            gt_q, gt_d;
    logic            lt_q, lt_d;
    logic            bit_ready_q, busy_q, done_q;
    logic            o1_q, o2_q, o3_q;

    logic            bit_gt, bit_eq, bit_lt;
    logic            first_diff;
    logic            finish;
    logic            xfer;

    bit_cmp u_bit_cmp (
        .a_i  (a_bit),
        .b_i  (b_bit),
        .gt_o (bit_gt),
        .eq_o (bit_eq),
        .lt_o (bit_lt)
    );

    // Next values of counter and sticky flags for an accepted bit pair
    always_comb begin
        xfer       = bit_valid & bit_ready_q;
        // Only the most significant differing bit decides the result
        first_diff = ~gt_q & ~lt_q & ~bit_eq;
        gt_d       = gt_q | (first_diff & bit_gt);
        lt_d       = lt_q | (first_diff & bit_lt);
        cnt_d      = cnt_q + CntW'(1);
`ifdef SERIAL_COMP_EARLY_TERM_EN
        finish     = (cnt_q == LastIdx) | first_diff;
`else
        finish     = (cnt_q == LastIdx);
`endif
    end

    // Control FSM with registered handshake, status and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            bit_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            o1_q        <= 1'b0;
            o2_q        <= 1'b1;
            o3_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q     <= SHIFT;
                        cnt_q       <= '0;
                        gt_q        <= 1'b0;
                        lt_q        <= 1'b0;
                        bit_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                        o1_q        <= 1'b0;
                        o2_q        <= 1'b1;
                        o3_q        <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    // start is deliberately ignored here
                    if (xfer) begin
                        cnt_q <= cnt_d;
                        gt_q  <= gt_d;
                        lt_q  <= lt_d;
                        if (finish) begin
                            state_q     <= DONE;
                            bit_ready_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            o1_q        <= gt_d;
                            o2_q        <= ~gt_d & ~lt_d;
                            o3_q        <= lt_d;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    bit_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bit_ready = bit_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign o1        = o1_q;
    assign o2        = o2_q;
    assign o3        = o3_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Self-checking bench for serial_mag_comp: directed scenarios followed by
// randomized operations, all checked against an arithmetic reference.
module tb_serial_mag_comp;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic bit_valid;
    logic a_bit;
    logic b_bit;
    logic bit_ready;
    logic busy;
    logic done;
    logic o1;
    logic o2;
    logic o3;

    int n_checks = 0;
    int n_errors = 0;

    serial_mag_comp #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_valid (bit_valid),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .bit_ready (bit_ready),
        .busy      (busy),
        .done      (done),
        .o1        (o1),
        .o2        (o2),
        .o3        (o3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Number of bit pairs the block should consume for this operand pair
    function automatic int exp_consumed(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_COMP_EARLY_TERM_EN
        for (int i = W - 1; i >= 0; i--) begin
            if (a[i] != b[i]) return W - i;
        end
`endif
        return W;
    endfunction

    function automatic logic [2:0] exp_result(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a > b) return 3'b100;
        if (a == b) return 3'b010;
        return 3'b001;
    endfunction

    // One comparison. mode: 0 = valid always high, 1 = valid toggling, 2 = random.
    // chained: start was already taken in the previous DONE cycle and one idle
    // SHIFT cycle has elapsed. hold_start: keep start high through DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int mode,
                          input bit chained, input bit hold_start);
        int         accepted;
        int         cyc;
        int         exp_n;
        bit         seen;
        bit         tgl;
        logic [2:0] exp_res;
        logic [2:0] res;
        logic       ready_at_done;

        accepted      = 0;
        seen          = 1'b0;
        tgl           = 1'b1;
        exp_n         = exp_consumed(a, b);
        exp_res       = exp_result(a, b);
        res           = 3'b000;
        ready_at_done = 1'b1;
        cyc           = chained ? 1 : 0;

        if (!chained) begin
            start     = 1'b1;
            bit_valid = 1'b0;
            @(posedge clk);
            #1;
        end

        while (!seen && cyc < 200) begin
            if (accepted < exp_n) begin
                case (mode)
                    0:       bit_valid = 1'b1;
                    1:       bit_valid = tgl;
                    default: bit_valid = 1'($urandom_range(0, 1));
                endcase
                tgl   = ~tgl;
                a_bit = a[W-1-accepted];
                b_bit = b[W-1-accepted];
                start = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
                bit_valid = 1'($urandom_range(0, 1));
                a_bit     = 1'($urandom_range(0, 1));
                b_bit     = 1'($urandom_range(0, 1));
                start     = hold_start;
            end
            @(negedge clk);
            cyc++;
            if (cyc == 1 && !chained) begin
                check("busy_in_shift", 32'(busy), 32'd1);
                check("ready_in_shift", 32'(bit_ready), 32'd1);
                check("cleared_on_start", 32'({o1, o2, o3}), 32'b010);
            end
            if (done) begin
                seen          = 1'b1;
                res           = {o1, o2, o3};
                ready_at_done = bit_ready;
            end else if (bit_valid && bit_ready) begin
                accepted++;
            end
            @(posedge clk);
            #1;
        end

        check("done_seen", 32'(seen), 32'd1);
        check("accepted_pairs", 32'(accepted), 32'(exp_n));
        check("result", 32'(res), 32'(exp_res));
        check("ready_low_at_done", 32'(ready_at_done), 32'd0);
        if (mode == 0) check("latency", 32'(cyc), 32'(exp_n + 1 + (chained ? 1 : 0)));

        start     = 1'b0;
        bit_valid = 1'b0;
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        if (hold_start) begin
            check("b2b_busy", 32'(busy), 32'd1);
            check("b2b_cleared", 32'({o1, o2, o3}), 32'b010);
        end else begin
            check("idle_busy", 32'(busy), 32'd0);
            check("result_held", 32'({o1, o2, o3}), 32'(exp_res));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit         hold;
        bit         chain;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int         seen_done;

        rst_n     = 1'b0;
        start     = 1'b0;
        bit_valid = 1'b0;
        a_bit     = 1'b0;
        b_bit     = 1'b0;
        #12;
        check("rst_outputs", 32'({o1, o2, o3}), 32'b010);
        check("rst_status", 32'({bit_ready, busy, done}), 32'b000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(8'hA5, 8'hA5, 0, 1'b0, 1'b0);
        run_op(8'h80, 8'h7F, 0, 1'b0, 1'b0);
        run_op(8'h01, 8'h02, 1, 1'b0, 1'b0);

        // Abort mid-operation with an asynchronous reset
        start = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        bit_valid = 1'b1;
        a_bit     = 1'b1;
        b_bit     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_outputs", 32'({o1, o2, o3}), 32'b010);
        check("abort_status", 32'({bit_ready, busy, done}), 32'b000);
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        @(posedge clk);
        #1;
        run_op(8'h00, 8'hFF, 0, 1'b0, 1'b0);

        // Back-to-back: start held through the DONE cycle
        run_op(8'h3C, 8'hC3, 0, 1'b0, 1'b1);
        run_op(8'h10, 8'h10, 0, 1'b1, 1'b0);

        chain = 1'b0;
        for (int n = 0; n < 24; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            if ($urandom_range(0, 1) == 1) rb[W-1] = ra[W-1];
            hold = (n == 23) ? 1'b0 : 1'($urandom_range(0, 1));
            run_op(ra, rb, int'($urandom_range(0, 2)), chain, hold);
            chain = hold;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_mag_comp.md
SERIAL_MAG_COMP -- requirements
Module: serial_mag_comp

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 1..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: begin a new comparison, sampled only in IDLE or DONE.
REQ-005 SHALL have port bit_valid, input, 1: a_bit/b_bit hold a valid bit pair.
REQ-006 SHALL have port a_bit, input, 1: serial operand A, MSB first.
REQ-007 SHALL have port b_bit, input, 1: serial operand B, MSB first.
REQ-008 SHALL have port bit_ready, output, 1: block accepts a bit pair this cycle.
REQ-009 SHALL have port busy, output, 1: high in SHIFT state.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when the result becomes valid.
REQ-011 SHALL have port o1, output, 1: A > B.
REQ-012 SHALL have port o2, output, 1: A == B.
REQ-013 SHALL have port o3, output, 1: A < B.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 SHALL transfer a bit pair only on a cycle with bit_valid && bit_ready both high; bit_ready SHALL equal (state == SHIFT).
REQ-016 IDLE/DONE + start SHALL go to SHIFT next cycle, clear the bit counter to 0, and set the running flags gt=0, lt=0.
REQ-017 On each transfer, if gt==0 and lt==0: a_bit & ~b_bit SHALL set gt, ~a_bit & b_bit SHALL set lt; once either flag is set it SHALL hold for the rest of the operation.
REQ-018 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL increment on each transfer; the transfer with counter == WIDTH-1 SHALL move SHIFT to DONE.
REQ-019 On entering DONE, o1/o2/o3 SHALL register {gt, ~gt&~lt, lt} including the final bit, and done SHALL pulse high for exactly one cycle.
REQ-020 Exactly one of o1/o2/o3 SHALL be high whenever a result is held; outputs SHALL hold until the next start is accepted.
REQ-021 Latency: done SHALL rise on the cycle after the last accepted bit pair; minimum start-to-done = WIDTH+1 cycles with bit_valid held high.
REQ-022 Gaps (bit_valid low) in SHIFT SHALL stall the FSM and leave counter and flags unchanged.
REQ-023 start asserted in SHIFT SHALL be ignored.
REQ-024 start asserted in the DONE cycle SHALL start a new operation (back-to-back), and outputs SHALL clear to o2=1 when SHIFT is entered.

Reset
REQ-025 rst_n low SHALL force state IDLE, counter 0, gt=lt=0, bit_ready=0, busy=0, done=0, o1=0, o2=1, o3=0, asynchronously.
REQ-026 Reset mid-SHIFT SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL behave as from power-up.

Configuration
REQ-027 Macro SERIAL_COMP_EARLY_TERM_EN: when defined, the transfer that first sets gt or lt SHALL move SHIFT to DONE immediately, the remaining bits SHALL NOT be consumed, and the result SHALL be the same as for a full-width compare.
REQ-028 When SERIAL_COMP_EARLY_TERM_EN is undefined, all WIDTH bit pairs SHALL always be consumed (REQ-018).

Structure
REQ-029 A shared package serial_comp_pkg SHALL hold the state enum typedef (IDLE, SHIFT, DONE) and the constant DEFAULT_WIDTH = 8.
REQ-030 The per-bit decision (gt/eq/lt of a_bit vs b_bit) SHALL be one sub-module instance, bit_cmp, that is purely combinational; the FSM, counter and flags SHALL be in serial_mag_comp.

Verification
REQ-031 WIDTH=8, A=0xA5, B=0xA5, bit_valid held high -> done at cycle 9 after start, o2=1, o1=o3=0.
REQ-032 A=0x80, B=0x7F -> o1=1; with SERIAL_COMP_EARLY_TERM_EN, done one cycle after the first bit and bit_ready low afterwards.
REQ-033 A=0x01, B=0x02 with bit_valid toggled 1,0,1,0... -> o3=1 and done only after 8 accepted pairs.
REQ-034 rst_n pulsed low after 4 bits of A=0xFF, B=0x00 -> outputs o2=1, no done; a new start with A=0x00, B=0xFF -> o3=1.
REQ-035 start held in the DONE cycle, second pair A=0x10, B=0x10 -> second done at 9 cycles later, o2=1; start pulses during SHIFT leave the count unchanged.
